// File: rtl/coh_pkg.sv
// Coherence message, opcode and MSI definitions shared by the node controllers and the directory.
package coh_pkg;

  localparam int unsigned MSG_W     = 22;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned PERF_W    = 16;

  localparam int unsigned OP_LSB   = 16;
  localparam int unsigned ADDR_LSB = 13;
  localparam int unsigned NODE_BIT = 12;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [MSG_W-1:0] IDLE_MSG = 22'h3FFFFF;

  // Node -> directory
  localparam logic [OP_W-1:0] OP_RD_MISS = 6'h01;
  localparam logic [OP_W-1:0] OP_WR_MISS = 6'h02;
  localparam logic [OP_W-1:0] OP_UPGRADE = 6'h03;
  localparam logic [OP_W-1:0] OP_WB      = 6'h04;
  // Directory -> node
  localparam logic [OP_W-1:0] OP_DATA_REPLY = 6'h10;
  localparam logic [OP_W-1:0] OP_INV        = 6'h11;
  localparam logic [OP_W-1:0] OP_FETCH      = 6'h12;
  localparam logic [OP_W-1:0] OP_FETCH_INV  = 6'h13;
  localparam logic [OP_W-1:0] OP_UPG_ACK    = 6'h14;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic              node;
    logic [DATA_W-1:0] data;
  } msg_t;

  function automatic logic [MSG_W-1:0] pack_msg(
    input logic [OP_W-1:0]   op,
    input logic [ADDR_W-1:0] addr,
    input logic              node,
    input logic [DATA_W-1:0] data
  );
    logic [MSG_W-1:0] m;
    m = '0;
    m[OP_LSB +: OP_W]     = op;
    m[ADDR_LSB +: ADDR_W] = addr;
    m[NODE_BIT]           = node;
    m[DATA_LSB +: DATA_W] = data;
    return m;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Four-line MSI state/tag/data store with a CPU-side write port and a snoop state-update port.
module cache_line_array
  import coh_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cpu_we_i,
  input  logic [IDX_W-1:0]                  cpu_idx_i,
  input  msi_e                              cpu_state_i,
  input  logic                              cpu_tag_i,
  input  logic [DATA_W-1:0]                 cpu_data_i,
  input  logic                              snp_we_i,
  input  logic [IDX_W-1:0]                  snp_idx_i,
  input  msi_e                              snp_state_i,
  output msi_e [NUM_LINES-1:0]              state_o,
  output logic [NUM_LINES-1:0]              tag_o,
  output logic [NUM_LINES-1:0][DATA_W-1:0]  data_o
);

  msi_e [NUM_LINES-1:0]             state_q;
  logic [NUM_LINES-1:0]             tag_q;
  logic [NUM_LINES-1:0][DATA_W-1:0] data_q;

  // Snoop write is applied last so it wins the line state on a same-line conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= MSI_I;
        tag_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      if (cpu_we_i) begin
        state_q[cpu_idx_i] <= cpu_state_i;
        tag_q[cpu_idx_i]   <= cpu_tag_i;
        data_q[cpu_idx_i]  <= cpu_data_i;
      end
      if (snp_we_i) begin
        state_q[snp_idx_i] <= snp_state_i;
      end
    end
  end

  assign state_o = state_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cache_node_ctrl.sv
// L1 MSI coherence controller for one node of the two-node directory system.
// Optional event counters are enabled with CACHE_NODE_PERF_EN.
module cache_node_ctrl #(
  parameter int unsigned                 NODE_ID  = 0,
  parameter logic [coh_pkg::MSG_W-1:0]   IDLE_MSG = coh_pkg::IDLE_MSG
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic                          cpu_we,
  input  logic [coh_pkg::ADDR_W-1:0]    cpu_addr,
  input  logic [coh_pkg::DATA_W-1:0]    cpu_wdata,
  output logic                          cpu_done,
  output logic [coh_pkg::DATA_W-1:0]    cpu_rdata,
  input  logic [coh_pkg::MSG_W-1:0]     msg_in,
  output logic [coh_pkg::MSG_W-1:0]     msg_out
`ifdef CACHE_NODE_PERF_EN
  ,
  output logic [coh_pkg::PERF_W-1:0]    perf_hits,
  output logic [coh_pkg::PERF_W-1:0]    perf_misses,
  output logic [coh_pkg::PERF_W-1:0]    perf_wbs
`endif
);

  import coh_pkg::*;

  localparam logic MY_NODE = 1'(NODE_ID);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_EVICT  = 3'd2,
    ST_REQ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } fsm_e;

  fsm_e               state_q, state_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_we_q, req_we_d;
  logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
  logic [OP_W-1:0]    req_op_q, req_op_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  msi_e [NUM_LINES-1:0]             line_state;
  logic [NUM_LINES-1:0]             line_tag;
  logic [NUM_LINES-1:0][DATA_W-1:0] line_data;

  logic               arr_we_c;
  msi_e               arr_state_c;
  logic               arr_tag_c;
  logic [DATA_W-1:0]  arr_data_c;

  msg_t               in_msg;
  logic               in_valid_c;
  logic [IDX_W-1:0]   snp_idx_c;
  logic               snp_we_c;
  msi_e               snp_state_c;
  logic               snp_wb_c;
  logic               snp_conflict_c;

  logic [IDX_W-1:0]   req_idx_c;
  logic               req_tag_c;
  logic               fsm_emit_c;
  logic [MSG_W-1:0]   fsm_msg_c;
  logic [OP_W-1:0]    send_op_c;
  logic               perf_hit_c, perf_miss_c, perf_wb_c;

  assign in_msg     = msg_t'(msg_in);
  assign in_valid_c = (msg_in != IDLE_MSG) && (in_msg.node == MY_NODE);
  assign snp_idx_c  = in_msg.addr[IDX_W-1:0];
  assign req_idx_c  = req_addr_q[IDX_W-1:0];
  assign req_tag_c  = req_addr_q[ADDR_W-1];

  cache_line_array u_lines (
    .clock       (clock),
    .reset       (reset),
    .cpu_we_i    (arr_we_c),
    .cpu_idx_i   (req_idx_c),
    .cpu_state_i (arr_state_c),
    .cpu_tag_i   (arr_tag_c),
    .cpu_data_i  (arr_data_c),
    .snp_we_i    (snp_we_c),
    .snp_idx_i   (snp_idx_c),
    .snp_state_i (snp_state_c),
    .state_o     (line_state),
    .tag_o       (line_tag),
    .data_o      (line_data)
  );

  // Directory-initiated snoops act on the line in the cycle they arrive.
  always_comb begin
    snp_we_c    = 1'b0;
    snp_state_c = MSI_I;
    snp_wb_c    = 1'b0;
    if (in_valid_c && (line_tag[snp_idx_c] == in_msg.addr[ADDR_W-1])) begin
      case (in_msg.op)
        OP_INV: begin
          if (line_state[snp_idx_c] == MSI_S) begin
            snp_we_c    = 1'b1;
            snp_state_c = MSI_I;
          end
        end
        OP_FETCH: begin
          if (line_state[snp_idx_c] == MSI_M) begin
            snp_we_c    = 1'b1;
            snp_state_c = MSI_S;
            snp_wb_c    = 1'b1;
          end
        end
        OP_FETCH_INV: begin
          if (line_state[snp_idx_c] == MSI_M) begin
            snp_we_c    = 1'b1;
            snp_state_c = MSI_I;
            snp_wb_c    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign snp_conflict_c = snp_we_c && (snp_idx_c == req_idx_c);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_op_q    <= OP_RD_MISS;
      msg_q       <= IDLE_MSG;
      done_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_op_q    <= req_op_d;
      msg_q       <= msg_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_op_d    = req_op_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    arr_we_c    = 1'b0;
    arr_state_c = MSI_I;
    arr_tag_c   = req_tag_c;
    arr_data_c  = line_data[req_idx_c];
    fsm_emit_c  = 1'b0;
    fsm_msg_c   = IDLE_MSG;
    send_op_c   = req_op_q;
    perf_hit_c  = 1'b0;
    perf_miss_c = 1'b0;
    perf_wb_c   = snp_wb_c;

    case (state_q)
      ST_IDLE: begin
        if (cpu_valid) begin
          req_addr_d  = cpu_addr;
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          state_d     = ST_LOOKUP;
        end
      end

      // Re-evaluate next cycle if a snoop is changing this very line.
      ST_LOOKUP: begin
        if (!snp_conflict_c) begin
          if ((line_state[req_idx_c] != MSI_I) && (line_tag[req_idx_c] == req_tag_c)) begin
            if (!req_we_q) begin
              rdata_d    = line_data[req_idx_c];
              done_d     = 1'b1;
              perf_hit_c = 1'b1;
              state_d    = ST_DONE;
            end else if (line_state[req_idx_c] == MSI_M) begin
              arr_we_c    = 1'b1;
              arr_state_c = MSI_M;
              arr_data_c  = req_wdata_q;
              rdata_d     = req_wdata_q;
              done_d      = 1'b1;
              perf_hit_c  = 1'b1;
              state_d     = ST_DONE;
            end else begin
              req_op_d    = OP_UPGRADE;
              perf_miss_c = 1'b1;
              state_d     = ST_REQ;
            end
          end else begin
            req_op_d    = req_we_q ? OP_WR_MISS : OP_RD_MISS;
            perf_miss_c = 1'b1;
            state_d     = (line_state[req_idx_c] == MSI_M) ? ST_EVICT : ST_REQ;
          end
        end
      end

      ST_EVICT: begin
        if (!snp_wb_c && !snp_conflict_c) begin
          if (line_state[req_idx_c] == MSI_M) begin
            fsm_emit_c  = 1'b1;
            fsm_msg_c   = pack_msg(OP_WB, {line_tag[req_idx_c], req_idx_c}, MY_NODE,
                                   line_data[req_idx_c]);
            arr_we_c    = 1'b1;
            arr_state_c = MSI_I;
            arr_tag_c   = line_tag[req_idx_c];
            perf_wb_c   = 1'b1;
          end
          state_d = ST_REQ;
        end
      end

      // An upgrade whose S copy was invalidated before it left becomes a write miss.
      ST_REQ: begin
        if ((req_op_q == OP_UPGRADE) &&
            !((line_state[req_idx_c] == MSI_S) && (line_tag[req_idx_c] == req_tag_c))) begin
          send_op_c = OP_WR_MISS;
        end
        if (!snp_wb_c) begin
          fsm_emit_c = 1'b1;
          fsm_msg_c  = pack_msg(send_op_c, req_addr_q, MY_NODE,
                                (send_op_c == OP_WR_MISS) ? req_wdata_q : '0);
          req_op_d   = send_op_c;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (in_valid_c) begin
          if ((in_msg.op == OP_DATA_REPLY) && (in_msg.addr == req_addr_q)) begin
            arr_we_c    = 1'b1;
            arr_state_c = req_we_q ? MSI_M : MSI_S;
            arr_data_c  = req_we_q ? req_wdata_q : in_msg.data;
            rdata_d     = arr_data_c;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else if ((in_msg.op == OP_UPG_ACK) && req_we_q) begin
            arr_we_c    = 1'b1;
            arr_state_c = MSI_M;
            arr_data_c  = req_wdata_q;
            rdata_d     = req_wdata_q;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A snoop write-back owns the bus; the FSM only emits when it is free.
  always_comb begin
    msg_d = IDLE_MSG;
    if (snp_wb_c) begin
      msg_d = pack_msg(OP_WB, in_msg.addr, MY_NODE, line_data[snp_idx_c]);
    end else if (fsm_emit_c) begin
      msg_d = fsm_msg_c;
    end
  end

  assign msg_out   = msg_q;
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;

`ifdef CACHE_NODE_PERF_EN
  logic [PERF_W-1:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (perf_hit_c && (hits_q != {PERF_W{1'b1}}))   hits_q   <= hits_q + PERF_W'(1);
      if (perf_miss_c && (misses_q != {PERF_W{1'b1}})) misses_q <= misses_q + PERF_W'(1);
      if (perf_wb_c && (wbs_q != {PERF_W{1'b1}}))     wbs_q    <= wbs_q + PERF_W'(1);
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
  assign perf_wbs    = wbs_q;
`else
  logic perf_unused_c;
  assign perf_unused_c = perf_hit_c ^ perf_miss_c ^ perf_wb_c;
`endif

endmodule
